// File: rtl/counter_timer_pkg.sv
// Shared register map and CFG field positions for the multi-channel counter/timer.
package counter_timer_pkg;

  localparam logic [1:0] ADDR_CFG    = 2'd0;
  localparam logic [1:0] ADDR_RELOAD = 2'd1;
  localparam logic [1:0] ADDR_VALUE  = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int CFG_EN      = 0;
  localparam int CFG_ONESHOT = 1;
  localparam int CFG_UPDOWN  = 2;
  localparam int CFG_CHAIN   = 3;
  localparam int CFG_IRQ_ENA = 4;
  localparam int CFG_PSC_LSB = 8;

  // Replace the bytes of old selected by we with the matching bytes of din.
  function automatic logic [31:0] byte_merge(input logic [31:0] old,
                                             input logic [31:0] din,
                                             input logic [3:0]  we);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (we[b]) r[b*8 +: 8] = din[b*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/counter_timer_chan.sv
// One counter/timer channel: config/reload/value registers, prescaler, terminal
// detection, registered tc pulse and sticky flag.
module counter_timer_chan
  import counter_timer_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int PSC_W     = 8,
  parameter bit CHAINABLE = 1'b1
) (
  input  logic        clkin,
  input  logic        resetn,
  input  logic [3:0]  we_cfg,
  input  logic [3:0]  we_reload,
  input  logic [3:0]  we_value,
  input  logic [3:0]  we_status,
  input  logic [31:0] wdata,
  input  logic        chain_tick,
  output logic [31:0] cfg_rd,
  output logic [31:0] reload_rd,
  output logic [31:0] value_rd,
  output logic [31:0] status_rd,
  output logic        tc_pulse,
  output logic        irq
);

  logic             enable_reg, oneshot_reg, updown_reg, chain_reg, irq_ena_reg;
  logic [PSC_W-1:0] psc_reg, psc_cnt_reg;
  logic [WIDTH-1:0] reload_reg, value_reg;
  logic             tc_pulse_reg, tc_flag_reg;

  logic [31:0]      cfg_new, reload_new, value_new;
  logic             cfg_wr, value_wr, start, tick, term_hit, terminal, flag_clr;
  logic [WIDTH-1:0] restart_value;
  logic             unused_bits;

  always_comb begin
    cfg_rd                         = '0;
    cfg_rd[CFG_EN]                 = enable_reg;
    cfg_rd[CFG_ONESHOT]            = oneshot_reg;
    cfg_rd[CFG_UPDOWN]             = updown_reg;
    cfg_rd[CFG_CHAIN]              = chain_reg;
    cfg_rd[CFG_IRQ_ENA]            = irq_ena_reg;
    cfg_rd[CFG_PSC_LSB +: PSC_W]   = psc_reg;
  end

  assign reload_rd  = 32'(reload_reg);
  assign value_rd   = 32'(value_reg);
  assign status_rd  = {31'b0, tc_flag_reg};

  assign cfg_new    = byte_merge(cfg_rd, wdata, we_cfg);
  assign reload_new = byte_merge(reload_rd, wdata, we_reload);
  assign value_new  = byte_merge(value_rd, wdata, we_value);
  assign unused_bits = ^{cfg_new, reload_new, value_new, wdata, we_status[3:1]};

  assign cfg_wr   = |we_cfg;
  assign value_wr = |we_value;
  // Only a 0->1 enable write restarts; an already-running channel never sees start.
  assign start    = cfg_wr && cfg_new[CFG_EN] && !enable_reg;
  assign tick     = enable_reg && ((CHAINABLE && chain_reg) ? chain_tick : (psc_cnt_reg == '0));
  assign term_hit = updown_reg ? (value_reg == reload_reg) : (value_reg == '0);
  assign terminal = tick && term_hit && !value_wr;
  assign restart_value = updown_reg ? '0 : reload_reg;
  assign flag_clr = we_status[0] && wdata[0];

  assign tc_pulse = tc_pulse_reg;
  assign irq      = tc_flag_reg & irq_ena_reg;

  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      enable_reg   <= 1'b0;
      oneshot_reg  <= 1'b0;
      updown_reg   <= 1'b0;
      chain_reg    <= 1'b0;
      irq_ena_reg  <= 1'b0;
      psc_reg      <= '0;
      psc_cnt_reg  <= '0;
      reload_reg   <= '0;
      value_reg    <= '0;
      tc_pulse_reg <= 1'b0;
      tc_flag_reg  <= 1'b0;
    end else begin
      if (cfg_wr) begin
        enable_reg  <= cfg_new[CFG_EN];
        oneshot_reg <= cfg_new[CFG_ONESHOT];
        updown_reg  <= cfg_new[CFG_UPDOWN];
        chain_reg   <= cfg_new[CFG_CHAIN];
        irq_ena_reg <= cfg_new[CFG_IRQ_ENA];
        psc_reg     <= cfg_new[CFG_PSC_LSB +: PSC_W];
      end else if (terminal && oneshot_reg) begin
        enable_reg  <= 1'b0;
      end

      if (|we_reload) reload_reg <= reload_new[WIDTH-1:0];

      // Software value writes take priority over both restart and counting.
      if (value_wr) begin
        value_reg <= value_new[WIDTH-1:0];
      end else if (start) begin
        value_reg <= cfg_new[CFG_UPDOWN] ? '0 : reload_reg;
      end else if (tick) begin
        if (terminal) begin
          if (!oneshot_reg) value_reg <= restart_value;
        end else if (updown_reg) begin
          value_reg <= value_reg + WIDTH'(1);
        end else begin
          value_reg <= value_reg - WIDTH'(1);
        end
      end

      if (start) begin
        psc_cnt_reg <= cfg_new[CFG_PSC_LSB +: PSC_W];
      end else if (enable_reg) begin
        psc_cnt_reg <= (psc_cnt_reg == '0) ? psc_reg : psc_cnt_reg - PSC_W'(1);
      end

      tc_pulse_reg <= terminal;
      tc_flag_reg  <= terminal || (tc_flag_reg && !flag_clr);
    end
  end

endmodule

// File: rtl/counter_timer_multi.sv
// Multi-channel counter/timer: register decode, read mux and chain wiring
// around NCHAN counter_timer_chan instances.
module counter_timer_multi
  import counter_timer_pkg::*;
#(
  parameter int NCHAN = 4,
  parameter int WIDTH = 32,
  parameter int PSC_W = 8
) (
  input  logic             clkin,
  input  logic             resetn,
  input  logic [2:0]       reg_ch,
  input  logic [1:0]       reg_addr,
  input  logic [3:0]       reg_we,
  input  logic [31:0]      reg_di,
  output logic [31:0]      reg_do,
  output logic [NCHAN-1:0] irq,
  output logic             irq_any
);

  logic [NCHAN-1:0] tc_pulse;
  logic [31:0]      cfg_rd    [NCHAN];
  logic [31:0]      reload_rd [NCHAN];
  logic [31:0]      value_rd  [NCHAN];
  logic [31:0]      status_rd [NCHAN];

  genvar gi;
  generate
    for (gi = 0; gi < NCHAN; gi++) begin : g_chan
      logic       sel;
      logic       chain_tick;
      logic [3:0] we_cfg, we_reload, we_value, we_status;

      assign sel       = (reg_ch == 3'(gi));
      assign we_cfg    = (sel && reg_addr == ADDR_CFG)    ? reg_we : 4'b0;
      assign we_reload = (sel && reg_addr == ADDR_RELOAD) ? reg_we : 4'b0;
      assign we_value  = (sel && reg_addr == ADDR_VALUE)  ? reg_we : 4'b0;
      assign we_status = (sel && reg_addr == ADDR_STATUS) ? reg_we : 4'b0;

      // Channel 0 has no predecessor, so its chain bit is inert.
      if (gi == 0) begin : g_head
        assign chain_tick = 1'b0;
      end else begin : g_link
        assign chain_tick = tc_pulse[gi-1];
      end

      counter_timer_chan #(
        .WIDTH     (WIDTH),
        .PSC_W     (PSC_W),
        .CHAINABLE (gi != 0)
      ) u_chan (
        .clkin      (clkin),
        .resetn     (resetn),
        .we_cfg     (we_cfg),
        .we_reload  (we_reload),
        .we_value   (we_value),
        .we_status  (we_status),
        .wdata      (reg_di),
        .chain_tick (chain_tick),
        .cfg_rd     (cfg_rd[gi]),
        .reload_rd  (reload_rd[gi]),
        .value_rd   (value_rd[gi]),
        .status_rd  (status_rd[gi]),
        .tc_pulse   (tc_pulse[gi]),
        .irq        (irq[gi])
      );
    end
  endgenerate

  assign irq_any = |irq;

  always_comb begin
    reg_do = '0;
    for (int i = 0; i < NCHAN; i++) begin
      if (reg_ch == 3'(i)) begin
        case (reg_addr)
          ADDR_CFG:    reg_do = cfg_rd[i];
          ADDR_RELOAD: reg_do = reload_rd[i];
          ADDR_VALUE:  reg_do = value_rd[i];
          ADDR_STATUS: reg_do = status_rd[i];
          default:     reg_do = '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_counter_timer_multi.sv
// Directed bench for counter_timer_multi with hand-computed expectations.
module tb_counter_timer_multi;
  import counter_timer_pkg::*;

  logic        clk;
  logic        resetn;
  logic [2:0]  reg_ch;
  logic [1:0]  reg_addr;
  logic [3:0]  reg_we;
  logic [31:0] reg_di;
  logic [31:0] reg_do;
  logic [3:0]  irq;
  logic        irq_any;

  int n_checks = 0;
  int n_pass   = 0;

  counter_timer_multi #(.NCHAN(4), .WIDTH(32), .PSC_W(8)) dut (
    .clkin    (clk),
    .resetn   (resetn),
    .reg_ch   (reg_ch),
    .reg_addr (reg_addr),
    .reg_we   (reg_we),
    .reg_di   (reg_di),
    .reg_do   (reg_do),
    .irq      (irq),
    .irq_any  (irq_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] ch, input logic [1:0] addr, input logic [3:0] we,
                    input logic [31:0] d);
    @(negedge clk);
    reg_ch = ch; reg_addr = addr; reg_we = we; reg_di = d;
    @(posedge clk);
    #1;
    reg_we = 4'b0;
    $display("wr ch=%0d addr=%0d we=%b data=%h", ch, addr, we, d);
  endtask

  task automatic chk_rd(input string tag, input logic [2:0] ch, input logic [1:0] addr,
                        input logic [31:0] exp);
    reg_ch = ch; reg_addr = addr;
    #1;
    chk(tag, reg_do, exp);
  endtask

  task automatic chk_pulse(input string tag, input int ch, input logic exp);
    chk(tag, {31'b0, dut.tc_pulse[ch]}, {31'b0, exp});
  endtask

  initial begin
    logic [31:0] seq_a [8] = '{32'd2, 32'd1, 32'd0, 32'd3, 32'd2, 32'd1, 32'd0, 32'd3};
    resetn = 1'b0; reg_ch = '0; reg_addr = '0; reg_we = '0; reg_di = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_rd("rst_cfg", 3'd0, ADDR_CFG, 32'h0);
    chk_rd("rst_value", 3'd0, ADDR_VALUE, 32'h0);
    chk_rd("rst_status", 3'd0, ADDR_STATUS, 32'h0);
    chk("rst_irq", {28'b0, irq}, 32'h0);
    chk("rst_irq_any", {31'b0, irq_any}, 32'h0);
    @(negedge clk) resetn = 1'b1;
    step();

    // Byte enables, unimplemented CFG bits, out-of-range channel
    wr(3'd2, ADDR_RELOAD, 4'b0010, 32'hAABBCCDD);
    chk_rd("byte_we", 3'd2, ADDR_RELOAD, 32'h0000CC00);
    wr(3'd2, ADDR_CFG, 4'hF, 32'hFFFFFFE0);
    chk_rd("cfg_mask", 3'd2, ADDR_CFG, 32'h0000FF00);
    wr(3'd2, ADDR_CFG, 4'hF, 32'h0);
    wr(3'd5, ADDR_RELOAD, 4'hF, 32'h55);
    chk_rd("bad_ch_rd", 3'd5, ADDR_RELOAD, 32'h0);
    chk_rd("bad_ch_alias", 3'd1, ADDR_RELOAD, 32'h0);

    // Ch0 down, RELOAD=3, psc=0, continuous
    wr(3'd0, ADDR_RELOAD, 4'hF, 32'd3);
    wr(3'd0, ADDR_CFG, 4'hF, 32'h1);
    chk_rd("a_start", 3'd0, ADDR_VALUE, 32'd3);
    for (int k = 1; k <= 8; k++) begin
      step();
      chk_rd("a_value", 3'd0, ADDR_VALUE, seq_a[k-1]);
      chk_pulse("a_pulse", 0, (k == 4) || (k == 8));
    end
    wr(3'd0, ADDR_CFG, 4'hF, 32'h0);
    repeat (3) step();
    chk_rd("a_frozen", 3'd0, ADDR_VALUE, 32'd2);
    chk_pulse("a_frozen_pulse", 0, 1'b0);
    chk_rd("a_flag", 3'd0, ADDR_STATUS, 32'd1);
    wr(3'd0, ADDR_STATUS, 4'b0001, 32'h1);
    chk_rd("a_flag_clr", 3'd0, ADDR_STATUS, 32'd0);

    // Ch1 up, RELOAD=5, psc=2, oneshot
    wr(3'd1, ADDR_RELOAD, 4'hF, 32'd5);
    wr(3'd1, ADDR_CFG, 4'hF, 32'h207);
    chk_rd("b_start", 3'd1, ADDR_VALUE, 32'd0);
    for (int k = 1; k <= 21; k++) begin
      step();
      chk_pulse("b_pulse", 1, k == 18);
      if (k == 17) chk_rd("b_value_pre", 3'd1, ADDR_VALUE, 32'd5);
    end
    chk_rd("b_value_hold", 3'd1, ADDR_VALUE, 32'd5);
    chk_rd("b_cfg_en_clr", 3'd1, ADDR_CFG, 32'h206);

    // Ch1 chained on ch0
    wr(3'd0, ADDR_RELOAD, 4'hF, 32'd1);
    wr(3'd1, ADDR_RELOAD, 4'hF, 32'd2);
    wr(3'd1, ADDR_CFG, 4'hF, 32'h9);
    wr(3'd0, ADDR_CFG, 4'hF, 32'h1);
    for (int k = 1; k <= 19; k++) begin
      step();
      chk_pulse("c_pulse0", 0, (k % 2) == 0);
      chk_pulse("c_pulse1", 1, (k == 7) || (k == 13) || (k == 19));
    end
    wr(3'd0, ADDR_CFG, 4'hF, 32'h0);
    wr(3'd1, ADDR_CFG, 4'hF, 32'h0);

    // Interrupts
    wr(3'd0, ADDR_STATUS, 4'b0001, 32'h1);
    chk("d_irq_idle", {31'b0, irq_any}, 32'h0);
    wr(3'd0, ADDR_RELOAD, 4'hF, 32'd2);
    wr(3'd0, ADDR_CFG, 4'hF, 32'h11);
    chk("d_irq_e0", {28'b0, irq}, 32'h0);
    step(); step();
    chk("d_irq_e2", {28'b0, irq}, 32'h0);
    step();
    chk("d_irq_e3", {28'b0, irq}, 32'h1);
    chk("d_irq_any", {31'b0, irq_any}, 32'h1);
    wr(3'd0, ADDR_CFG, 4'hF, 32'h10);
    chk("d_irq_held", {28'b0, irq}, 32'h1);
    wr(3'd0, ADDR_STATUS, 4'b0001, 32'h1);
    chk("d_irq_w1c", {28'b0, irq}, 32'h0);
    chk("d_irq_any_w1c", {31'b0, irq_any}, 32'h0);
    wr(3'd0, ADDR_RELOAD, 4'hF, 32'd0);
    wr(3'd0, ADDR_CFG, 4'hF, 32'h11);
    step();
    chk("d_irq_every", {28'b0, irq}, 32'h1);
    wr(3'd0, ADDR_STATUS, 4'b0001, 32'h1);
    chk("d_set_wins", {28'b0, irq}, 32'h1);
    wr(3'd0, ADDR_CFG, 4'hF, 32'h0);
    chk("d_irq_ena_off", {28'b0, irq}, 32'h0);
    chk_rd("d_flag_kept", 3'd0, ADDR_STATUS, 32'd1);
    wr(3'd0, ADDR_STATUS, 4'b0001, 32'h1);

    // Up-mode wrap at full width, value write overriding a tick
    wr(3'd3, ADDR_RELOAD, 4'hF, 32'hFFFFFFFF);
    wr(3'd3, ADDR_CFG, 4'hF, 32'h5);
    wr(3'd3, ADDR_VALUE, 4'hF, 32'hFFFFFFFE);
    chk_rd("e_written", 3'd3, ADDR_VALUE, 32'hFFFFFFFE);
    step();
    chk_rd("e_max", 3'd3, ADDR_VALUE, 32'hFFFFFFFF);
    chk_pulse("e_pulse_pre", 3, 1'b0);
    step();
    chk_rd("e_reload0", 3'd3, ADDR_VALUE, 32'h0);
    chk_pulse("e_pulse", 3, 1'b1);
    wr(3'd3, ADDR_CFG, 4'hF, 32'h0);

    // Asynchronous reset mid-count
    wr(3'd2, ADDR_RELOAD, 4'hF, 32'd0);
    wr(3'd2, ADDR_CFG, 4'hF, 32'h11);
    step();
    chk("f_irq_pre", {31'b0, irq_any}, 32'h1);
    wr(3'd0, ADDR_RELOAD, 4'hF, 32'd3);
    wr(3'd0, ADDR_CFG, 4'hF, 32'h1);
    step(); step();
    chk_rd("f_counting", 3'd0, ADDR_VALUE, 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("f_irq_any_rst", {31'b0, irq_any}, 32'h0);
    chk("f_irq_rst", {28'b0, irq}, 32'h0);
    chk_rd("f_value_rst", 3'd0, ADDR_VALUE, 32'h0);
    chk_rd("f_cfg_rst", 3'd0, ADDR_CFG, 32'h0);
    chk_rd("f_reload_rst", 3'd2, ADDR_RELOAD, 32'h0);
    @(negedge clk) resetn = 1'b1;
    repeat (3) step();
    chk_rd("f_idle_value", 3'd0, ADDR_VALUE, 32'h0);
    chk("f_idle_pulse", {28'b0, dut.tc_pulse}, 32'h0);
    chk("f_idle_irq", {28'b0, irq}, 32'h0);
    wr(3'd0, ADDR_RELOAD, 4'hF, 32'd3);
    wr(3'd0, ADDR_CFG, 4'hF, 32'h1);
    chk_rd("f_restart", 3'd0, ADDR_VALUE, 32'd3);
    step();
    chk_rd("f_resume", 3'd0, ADDR_VALUE, 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
